// File: rtl/param_datapath_pkg.sv
// Shared control encodings, the multiplier state type and a signed-overflow
// helper for the parametrised datapath.
package param_datapath_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_NOT = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        VSEL_DOUT  = 2'b00,
        VSEL_PC    = 2'b01,
        VSEL_IMM8  = 2'b10,
        VSEL_MDATA = 2'b11
    } vsel_e;

    typedef enum logic [1:0] {
        BSEL_SHIFT     = 2'b00,
        BSEL_IMM5      = 2'b01,
        BSEL_ZERO      = 2'b10,
        BSEL_SHIFT_ALT = 2'b11
    } bsel_e;

    typedef enum logic [1:0] {
        SH_PASS = 2'b00,
        SH_LSL  = 2'b01,
        SH_LSR  = 2'b10,
        SH_ASR  = 2'b11
    } shift_e;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_RUN  = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_e;

    // Subtraction overflows like an add of the inverted B operand's sign.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic r_msb, input logic is_sub);
        logic b_eff;
        b_eff = b_msb ^ is_sub;
        return (a_msb == b_eff) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/param_datapath_seq_mult.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// done strobes during the last RUN cycle; product/ovf are valid with it.
module seq_mult
    import param_datapath_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] product,
    output logic         ovf
);
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

    mul_state_e       state_r;
    logic [2*W-1:0]   mcand_r;
    logic [2*W-1:0]   acc_r;
    logic [2*W-1:0]   acc_next_s;
    logic [W-1:0]     mplier_r;
    logic [CW-1:0]    cnt_r;

    // Accumulator value after this cycle's conditional add.
    always_comb begin
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    assign busy    = (state_r != MUL_IDLE);
    assign done    = (state_r == MUL_RUN) && (cnt_r == LAST_CNT);
    assign product = acc_next_s[W-1:0];
    assign ovf     = |acc_next_s[2*W-1:W];

    // Multiplier FSM and operand/accumulator registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= MUL_IDLE;
            mcand_r  <= {(2*W){1'b0}};
            acc_r    <= {(2*W){1'b0}};
            mplier_r <= {W{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else begin
            case (state_r)
                MUL_IDLE: begin
                    if (start) begin
                        state_r  <= MUL_RUN;
                        mcand_r  <= {{W{1'b0}}, a};
                        mplier_r <= b;
                        acc_r    <= {(2*W){1'b0}};
                        cnt_r    <= {CW{1'b0}};
                    end
                end
                MUL_RUN: begin
                    acc_r    <= acc_next_s;
                    mcand_r  <= {mcand_r[2*W-2:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[W-1:1]};
                    cnt_r    <= cnt_r + CW'(1);
                    if (cnt_r == LAST_CNT) begin
                        state_r <= MUL_DONE;
                    end
                end
                MUL_DONE: begin
                    state_r <= MUL_IDLE;
                end
                default: begin
                    state_r <= MUL_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/param_datapath.sv
// W-bit datapath: register file, A/B operands, four-way shifter, ALU,
// C result and NVZ status, plus an attached sequential multiplier.
module param_datapath
    import param_datapath_pkg::*;
#(
    parameter  int W    = 16,
    parameter  int NREG = 8,
    parameter  int PCW  = 8,
    localparam int RW   = $clog2(NREG)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [RW-1:0]  readnum,
    input  logic [RW-1:0]  writenum,
    input  logic           write,
    input  logic [1:0]     vsel,
    input  logic           loada,
    input  logic           loadb,
    input  logic [1:0]     shift,
    input  logic           asel,
    input  logic [1:0]     bsel,
    input  logic [1:0]     ALUop,
    input  logic           loadc,
    input  logic           loads,
    input  logic           mul_start,
    input  logic [W-1:0]   mdata,
    input  logic [W-1:0]   sximm8,
    input  logic [W-1:0]   sximm5,
    input  logic [PCW-1:0] PC,
    output logic [W-1:0]   datapath_out,
    output logic           N,
    output logic           V,
    output logic           Z,
    output logic           busy,
    output logic           done
);
    logic [W-1:0] regs_r [NREG];
    logic [W-1:0] a_r;
    logic [W-1:0] b_r;
    logic [W-1:0] c_r;
    logic         n_r;
    logic         v_r;
    logic         z_r;
    logic         done_r;

    logic [W-1:0] rdata_s;
    logic [W-1:0] wdata_s;
    logic [W-1:0] pc_inc_s;
    logic [W-1:0] shout_s;
    logic [W-1:0] ain_s;
    logic [W-1:0] bin_s;
    logic [W-1:0] alu_s;
    logic         alu_v_s;
    logic         mul_busy_s;
    logic         mul_fin_s;
    logic         mul_ovf_s;
    logic [W-1:0] mul_prod_s;

    assign rdata_s  = regs_r[readnum];
    assign pc_inc_s = W'(PC) + {{(W-1){1'b0}}, 1'b1};

    // Register-file write-data select.
    always_comb begin
        case (vsel_e'(vsel))
            VSEL_MDATA: wdata_s = mdata;
            VSEL_IMM8:  wdata_s = sximm8;
            VSEL_PC:    wdata_s = pc_inc_s;
            VSEL_DOUT:  wdata_s = c_r;
            default:    wdata_s = c_r;
        endcase
    end

    // Shifter on the B operand.
    always_comb begin
        case (shift_e'(shift))
            SH_PASS: shout_s = b_r;
            SH_LSL:  shout_s = {b_r[W-2:0], 1'b0};
            SH_LSR:  shout_s = {1'b0, b_r[W-1:1]};
            SH_ASR:  shout_s = {b_r[W-1], b_r[W-1:1]};
            default: shout_s = b_r;
        endcase
    end

    // Operand selection into the ALU and multiplier.
    always_comb begin
        if (asel) begin
            ain_s = {W{1'b0}};
        end else begin
            ain_s = a_r;
        end
        case (bsel_e'(bsel))
            BSEL_SHIFT:     bin_s = shout_s;
            BSEL_IMM5:      bin_s = sximm5;
            BSEL_ZERO:      bin_s = {W{1'b0}};
            BSEL_SHIFT_ALT: bin_s = shout_s;
            default:        bin_s = shout_s;
        endcase
    end

    // ALU result and signed-overflow flag.
    always_comb begin
        alu_s   = {W{1'b0}};
        alu_v_s = 1'b0;
        case (alu_op_e'(ALUop))
            ALU_ADD: begin
                alu_s   = ain_s + bin_s;
                alu_v_s = signed_ovf(ain_s[W-1], bin_s[W-1], alu_s[W-1], 1'b0);
            end
            ALU_SUB: begin
                alu_s   = ain_s - bin_s;
                alu_v_s = signed_ovf(ain_s[W-1], bin_s[W-1], alu_s[W-1], 1'b1);
            end
            ALU_AND: alu_s = ain_s & bin_s;
            ALU_NOT: alu_s = ~bin_s;
            default: alu_s = {W{1'b0}};
        endcase
    end

    seq_mult #(.W(W)) u_mult (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (ain_s),
        .b       (bin_s),
        .busy    (mul_busy_s),
        .done    (mul_fin_s),
        .product (mul_prod_s),
        .ovf     (mul_ovf_s)
    );

    // Register file: reads see the value from before this edge's write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {W{1'b0}};
            end
        end else if (write) begin
            regs_r[writenum] <= wdata_s;
        end
    end

    // A/B operand registers, loadable even while a multiply runs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r <= {W{1'b0}};
            b_r <= {W{1'b0}};
        end else begin
            if (loada) a_r <= rdata_s;
            if (loadb) b_r <= rdata_s;
        end
    end

    // C and status: the multiplier owns them while busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_r    <= {W{1'b0}};
            n_r    <= 1'b0;
            v_r    <= 1'b0;
            z_r    <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= mul_fin_s;
            if (mul_fin_s) begin
                c_r <= mul_prod_s;
                n_r <= mul_prod_s[W-1];
                z_r <= (mul_prod_s == {W{1'b0}});
                v_r <= mul_ovf_s;
            end else if (!mul_busy_s) begin
                if (loadc) c_r <= alu_s;
                if (loads) begin
                    n_r <= alu_s[W-1];
                    z_r <= (alu_s == {W{1'b0}});
                    v_r <= alu_v_s;
                end
            end
        end
    end

    assign datapath_out = c_r;
    assign N            = n_r;
    assign V            = v_r;
    assign Z            = z_r;
    assign busy         = mul_busy_s;
    assign done         = done_r;

endmodule

// File: tb/tb_param_datapath.sv
// Self-checking bench for param_datapath (W=16, NREG=8): directed scenarios
// plus randomized control traffic against a cycle-level arithmetic model.
module tb_param_datapath;
    localparam int W    = 16;
    localparam int NREG = 8;
    localparam int PCW  = 8;

    logic           clk;
    logic           reset;
    logic [2:0]     readnum, writenum;
    logic           write, loada, loadb, asel, loadc, loads, mul_start;
    logic [1:0]     vsel, shift, bsel, ALUop;
    logic [W-1:0]   mdata, sximm8, sximm5;
    logic [PCW-1:0] PC;
    logic [W-1:0]   datapath_out;
    logic           N, V, Z, busy, done;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [15:0] m_rf [NREG];
    logic [15:0] m_a, m_b, m_c;
    logic        m_n, m_v, m_z;
    int          m_rem;
    logic [31:0] m_prod;

    param_datapath #(.W(W), .NREG(NREG), .PCW(PCW)) dut (
        .clk(clk), .reset(reset), .readnum(readnum), .writenum(writenum),
        .write(write), .vsel(vsel), .loada(loada), .loadb(loadb),
        .shift(shift), .asel(asel), .bsel(bsel), .ALUop(ALUop),
        .loadc(loadc), .loads(loads), .mul_start(mul_start),
        .mdata(mdata), .sximm8(sximm8), .sximm5(sximm5), .PC(PC),
        .datapath_out(datapath_out), .N(N), .V(V), .Z(Z),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int to_signed16(input int unsigned x);
        return (x >= 32768) ? int'(x) - 65536 : int'(x);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_rf[i] = 16'h0000;
        m_a = 16'h0000; m_b = 16'h0000; m_c = 16'h0000;
        m_n = 1'b0; m_v = 1'b0; m_z = 1'b0;
        m_rem = 0; m_prod = 32'h0;
    endtask

    // One clock edge of behaviour, computed from pre-edge model state.
    task automatic model_edge();
        int unsigned bv, sh, bin, ain, res;
        int          sres;
        logic        ov;
        logic [15:0] rd, wd;
        if (reset) begin
            model_reset();
        end else begin
            rd = m_rf[readnum];
            bv = m_b;
            case (shift)
                2'd1:    sh = (bv * 2) % 65536;
                2'd2:    sh = bv / 2;
                2'd3:    sh = bv / 2 + ((bv >= 32768) ? 32768 : 0);
                default: sh = bv;
            endcase
            bin = (bsel == 2'd1) ? int'(sximm5) : (bsel == 2'd2) ? 0 : sh;
            ain = asel ? 0 : m_a;
            ov  = 1'b0;
            case (ALUop)
                2'd0: begin
                    res  = (ain + bin) % 65536;
                    sres = to_signed16(ain) + to_signed16(bin);
                    ov   = (sres > 32767) || (sres < -32768);
                end
                2'd1: begin
                    res  = (ain + 65536 - bin) % 65536;
                    sres = to_signed16(ain) - to_signed16(bin);
                    ov   = (sres > 32767) || (sres < -32768);
                end
                2'd2:    res = ain & bin;
                default: res = 65535 - bin;
            endcase
            case (vsel)
                2'd3:    wd = mdata;
                2'd2:    wd = sximm8;
                2'd1:    wd = 16'(PC) + 16'd1;
                default: wd = m_c;
            endcase
            if (write) m_rf[writenum] = wd;
            if (loada) m_a = rd;
            if (loadb) m_b = rd;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 1) begin
                    m_c = m_prod[15:0];
                    m_n = m_prod[15];
                    m_z = (m_prod[15:0] == 16'h0000);
                    m_v = (m_prod[31:16] != 16'h0000);
                end
            end else begin
                if (loadc) m_c = 16'(res);
                if (loads) begin
                    m_n = (res >= 32768);
                    m_z = (res == 0);
                    m_v = ov;
                end
                if (mul_start) begin
                    m_rem  = W + 1;
                    m_prod = ain * bin;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("out",  datapath_out, m_c);
        check_eq("nvz",  {N, V, Z}, {m_n, m_v, m_z});
        check_eq("busy", busy, m_rem > 0);
        check_eq("done", done, m_rem == 1);
    endtask

    task automatic idle();
        write = 1'b0; loada = 1'b0; loadb = 1'b0; loadc = 1'b0; loads = 1'b0;
        mul_start = 1'b0; asel = 1'b0; bsel = 2'd0; shift = 2'd0; ALUop = 2'd0;
        vsel = 2'd0;
    endtask

    task automatic load_ab(input logic [15:0] av, input logic [15:0] bv);
        idle(); write = 1'b1; vsel = 2'd2;
        writenum = 3'd0; sximm8 = av; cycle();
        writenum = 3'd1; sximm8 = bv; cycle();
        idle(); readnum = 3'd0; loada = 1'b1; cycle();
        loada = 1'b0; readnum = 3'd1; loadb = 1'b1; cycle();
        idle();
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            cycle();
            n++;
        end
        check_eq("done_seen", done, 1'b1);
    endtask

    initial begin
        reset = 1'b1; readnum = 3'd0; writenum = 3'd0; mdata = 16'h0;
        sximm8 = 16'h0; sximm5 = 16'h0; PC = 8'h0;
        idle();
        model_reset();
        #1;
        check_eq("rst_out", datapath_out, 16'h0000);
        check_eq("rst_nvz", {N, V, Z}, 3'b000);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        cycle();
        reset = 1'b0;

        // 1: immediate write, readback through A and an add with zero
        write = 1'b1; writenum = 3'd3; vsel = 2'd2; sximm8 = 16'h0007; cycle();
        idle(); readnum = 3'd3; loada = 1'b1; cycle();
        idle(); bsel = 2'd2; loadc = 1'b1; loads = 1'b1; cycle();
        check_eq("t1_out", datapath_out, 16'h0007);
        check_eq("t1_nvz", {N, V, Z}, 3'b000);
        for (int r = 0; r < NREG; r++) begin
            if (r != 3) begin
                idle(); readnum = 3'(r); loada = 1'b1; cycle();
                idle(); bsel = 2'd2; loadc = 1'b1; cycle();
                check_eq("t1_reg_zero", datapath_out, 16'h0000);
            end
        end

        // 2: subtract overflow
        load_ab(16'h7FFF, 16'hFFFF);
        ALUop = 2'd1; loadc = 1'b1; loads = 1'b1; cycle();
        check_eq("t2_out", datapath_out, 16'h8000);
        check_eq("t2_nvz", {N, V, Z}, 3'b110);

        // 3: 3 x 5, exact latency
        load_ab(16'h0003, 16'h0005);
        mul_start = 1'b1; cycle();
        idle();
        check_eq("t3_busy0", busy, 1'b1);
        for (int i = 1; i <= W; i++) begin
            cycle();
            check_eq("t3_busy", busy, 1'b1);
            check_eq("t3_done_at", done, i == W);
        end
        check_eq("t3_out", datapath_out, 16'h000F);
        check_eq("t3_nvz", {N, V, Z}, 3'b000);
        cycle();
        check_eq("t3_busy_end", busy, 1'b0);

        // 4: product overflows into the high half
        load_ab(16'h0100, 16'h0100);
        mul_start = 1'b1; cycle(); idle();
        wait_done();
        check_eq("t4_out", datapath_out, 16'h0000);
        check_eq("t4_nvz", {N, V, Z}, 3'b011);
        cycle();

        // 5a: loadc and a second start while busy are ignored
        load_ab(16'h0003, 16'h0005);
        mul_start = 1'b1; cycle();
        asel = 1'b1; bsel = 2'd1; sximm5 = 16'h1234; loadc = 1'b1; loads = 1'b1;
        repeat (8) cycle();
        idle();
        wait_done();
        check_eq("t5_out", datapath_out, 16'h000F);
        cycle();

        // 5b: reset in RUN cycle 5 aborts the multiply
        mul_start = 1'b1; cycle(); idle();
        repeat (5) cycle();
        reset = 1'b1;
        #1;
        model_reset();
        check_eq("t5_rst_busy", busy, 1'b0);
        check_eq("t5_rst_done", done, 1'b0);
        check_eq("t5_rst_out", datapath_out, 16'h0000);
        check_eq("t5_rst_nvz", {N, V, Z}, 3'b000);
        cycle(); cycle();
        reset = 1'b0;
        repeat (20) begin
            cycle();
            check_eq("t5_no_done", done, 1'b0);
        end

        // 6: arithmetic and logical right shift of B
        load_ab(16'h0000, 16'h8004);
        shift = 2'd3; asel = 1'b1; loadc = 1'b1; loads = 1'b1; cycle();
        check_eq("t6_asr", datapath_out, 16'hC002);
        check_eq("t6_asr_nvz", {N, V, Z}, 3'b100);
        shift = 2'd2; cycle();
        check_eq("t6_lsr", datapath_out, 16'h4002);
        check_eq("t6_lsr_nvz", {N, V, Z}, 3'b000);
        idle();

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            readnum   = 3'($urandom_range(0, 7));
            writenum  = 3'($urandom_range(0, 7));
            write     = 1'($urandom_range(0, 1));
            vsel      = 2'($urandom_range(0, 3));
            loada     = 1'($urandom_range(0, 1));
            loadb     = 1'($urandom_range(0, 1));
            shift     = 2'($urandom_range(0, 3));
            asel      = ($urandom_range(0, 3) == 0);
            bsel      = 2'($urandom_range(0, 3));
            ALUop     = 2'($urandom_range(0, 3));
            loadc     = 1'($urandom_range(0, 1));
            loads     = 1'($urandom_range(0, 1));
            mul_start = ($urandom_range(0, 7) == 0);
            mdata     = 16'($urandom);
            sximm8    = 16'($urandom);
            sximm5    = 16'($urandom);
            PC        = 8'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
